rvj1_mem_arbiter: RTL and testbench

//  Shares the single core-side memory port between the instruction fetch unit (IFU) and the LSU.
//  - One outstanding transaction at a time; routes each response back to its owner.
//  - LSU has fixed priority; a streak limit prevents IFU starvation.
//  - Sits between the IFU/LSU and the memory interface.

---
 rtl/rvj1_mem_arbiter.sv | 127 ++++++++++++
 tb/tb_rvj1_mem_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rvj1_mem_arbiter.sv
// Shares one memory port between the IFU and the LSU: one transaction in flight,
// LSU has fixed priority, and a streak counter bounds how long the IFU can be starved.
module rvj1_mem_arbiter #(
  parameter int XLEN           = 32,
  parameter int MAX_LSU_STREAK = 4
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic            ifu_req_i,
  input  logic [XLEN-1:0] ifu_addr_i,
  output logic            ifu_gnt_o,
  output logic            ifu_rvalid_o,
  output logic [XLEN-1:0] ifu_rdata_o,
  input  logic            lsu_req_i,
  input  logic            lsu_we_i,
  input  logic [3:0]      lsu_be_i,
  input  logic [XLEN-1:0] lsu_addr_i,
  input  logic [XLEN-1:0] lsu_wdata_i,
  output logic            lsu_gnt_o,
  output logic            lsu_rvalid_o,
  output logic [XLEN-1:0] lsu_rdata_o,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [3:0]      mem_be_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [XLEN-1:0] mem_wdata_o,
  input  logic            mem_gnt_i,
  input  logic            mem_rvalid_i,
  input  logic [XLEN-1:0] mem_rdata_i,
  output logic            busy_o
);

  localparam int SW = $clog2(MAX_LSU_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_LSU_STREAK);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;

  state_e        state_q, state_d;
  logic          owner_q, owner_d;   // 1 = LSU, 0 = IFU
  logic [SW-1:0] streak_q, streak_d;
  logic          sel_lsu;
  logic          cur_lsu;
  logic          issue;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= S_IDLE;
      owner_q  <= 1'b0;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      streak_q <= streak_d;
    end
  end

  assign ifu_rdata_o = mem_rdata_i;
  assign lsu_rdata_o = mem_rdata_i;
  assign busy_o      = (state_q != S_IDLE);

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    streak_d     = streak_q;
    ifu_gnt_o    = 1'b0;
    lsu_gnt_o    = 1'b0;
    ifu_rvalid_o = 1'b0;
    lsu_rvalid_o = 1'b0;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_be_o     = 4'b0000;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    issue        = 1'b0;
    cur_lsu      = owner_q;
    sel_lsu      = lsu_req_i && !(ifu_req_i && (streak_q == STREAK_MAX));

    // Outputs are gated by reset so requesters see silence while rstn_i is low.
    if (rstn_i) begin
      case (state_q)
        S_IDLE: begin
          if (lsu_req_i || ifu_req_i) begin
            issue   = 1'b1;
            cur_lsu = sel_lsu;
            owner_d = sel_lsu;
          end
        end
        S_REQ: begin
          issue = 1'b1;
        end
        S_WAIT: begin
          if (mem_rvalid_i) begin
            ifu_rvalid_o = !owner_q;
            lsu_rvalid_o = owner_q;
            state_d      = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (issue) begin
      mem_req_o = 1'b1;
      state_d   = mem_gnt_i ? S_WAIT : S_REQ;
      if (cur_lsu) begin
        mem_we_o    = lsu_we_i;
        mem_be_o    = lsu_be_i;
        mem_addr_o  = lsu_addr_i;
        mem_wdata_o = lsu_wdata_i;
      end else begin
        mem_be_o    = 4'b1111;
        mem_addr_o  = ifu_addr_i;
      end
      if (mem_gnt_i) begin
        ifu_gnt_o = !cur_lsu;
        lsu_gnt_o = cur_lsu;
        // Streak only grows while the IFU is actually being held off.
        if (cur_lsu && ifu_req_i) begin
          if (streak_q != STREAK_MAX) streak_d = streak_q + 1'b1;
        end else begin
          streak_d = '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_rvj1_mem_arbiter.sv
// Directed bench for rvj1_mem_arbiter: expected grants and responses are queued
// as stimulus is written and checked when the arbiter produces them.
module tb_rvj1_mem_arbiter;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        ifu_req_i;
  logic [31:0] ifu_addr_i;
  logic        ifu_gnt_o, ifu_rvalid_o;
  logic [31:0] ifu_rdata_o;
  logic        lsu_req_i, lsu_we_i;
  logic [3:0]  lsu_be_i;
  logic [31:0] lsu_addr_i, lsu_wdata_i;
  logic        lsu_gnt_o, lsu_rvalid_o;
  logic [31:0] lsu_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_gnt_i, mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        busy_o;

  rvj1_mem_arbiter #(.XLEN(32), .MAX_LSU_STREAK(4)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .ifu_req_i(ifu_req_i), .ifu_addr_i(ifu_addr_i), .ifu_gnt_o(ifu_gnt_o),
    .ifu_rvalid_o(ifu_rvalid_o), .ifu_rdata_o(ifu_rdata_o),
    .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_be_i(lsu_be_i),
    .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i), .lsu_gnt_o(lsu_gnt_o),
    .lsu_rvalid_o(lsu_rvalid_o), .lsu_rdata_o(lsu_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        lsu;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } gnt_t;

  typedef struct {
    logic        lsu;
    logic [31:0] rdata;
  } rsp_t;

  gnt_t exp_gnt[$];
  rsp_t exp_rsp[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic saw_ifu_gnt = 1'b0;
  logic saw_lsu_gnt = 1'b0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic push_gnt(input logic lsu, input logic we, input logic [3:0] be,
                          input logic [31:0] addr, input logic [31:0] wdata);
    gnt_t g;
    g.lsu = lsu; g.we = we; g.be = be; g.addr = addr; g.wdata = wdata;
    exp_gnt.push_back(g);
  endtask

  task automatic push_rsp(input logic lsu, input logic [31:0] rdata);
    rsp_t r;
    r.lsu = lsu; r.rdata = rdata;
    exp_rsp.push_back(r);
  endtask

  // Scoreboard side: every grant/response pulse must match the head of its queue.
  task automatic monitor();
    gnt_t g;
    rsp_t r;
    if (ifu_gnt_o || lsu_gnt_o) begin
      saw_ifu_gnt = ifu_gnt_o;
      saw_lsu_gnt = lsu_gnt_o;
      if (exp_gnt.size() == 0) begin
        chk("gnt_unexpected", {126'd0, ifu_gnt_o, lsu_gnt_o}, 128'd0);
      end else begin
        g = exp_gnt.pop_front();
        chk("gnt", {lsu_gnt_o, ifu_gnt_o, mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o},
            {g.lsu, !g.lsu, 1'b1, g.we, g.be, g.addr, g.wdata});
      end
    end
    if (ifu_rvalid_o || lsu_rvalid_o) begin
      if (exp_rsp.size() == 0) begin
        chk("rvalid_unexpected", {126'd0, ifu_rvalid_o, lsu_rvalid_o}, 128'd0);
      end else begin
        r = exp_rsp.pop_front();
        chk("rsp", {lsu_rvalid_o, ifu_rvalid_o, ifu_rdata_o, lsu_rdata_o},
            {r.lsu, !r.lsu, r.rdata, r.rdata});
      end
    end
  endtask

  task automatic drive(input logic g, input logic rv, input logic [31:0] rd);
    mem_gnt_i    = g;
    mem_rvalid_i = rv;
    mem_rdata_i  = rd;
    #2;
    monitor();
  endtask

  // Advance one clock; a requester drops its request once it has been granted.
  task automatic step();
    @(posedge clk_i);
    #1;
    if (saw_ifu_gnt) ifu_req_i = 1'b0;
    if (saw_lsu_gnt) lsu_req_i = 1'b0;
    saw_ifu_gnt  = 1'b0;
    saw_lsu_gnt  = 1'b0;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rstn_i = 1'b0;
    ifu_req_i = 1'b0; ifu_addr_i = '0;
    lsu_req_i = 1'b0; lsu_we_i = 1'b0; lsu_be_i = '0; lsu_addr_i = '0; lsu_wdata_i = '0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("reset_outputs", {busy_o, mem_req_o, ifu_gnt_o, lsu_gnt_o, ifu_rvalid_o, lsu_rvalid_o,
                          mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o}, 128'd0);
    rstn_i = 1'b1;

    // Single IFU read, granted immediately, response one cycle later.
    ifu_req_i = 1'b1; ifu_addr_i = 32'h8000_0000;
    push_gnt(1'b0, 1'b0, 4'b1111, 32'h8000_0000, 32'h0);
    push_rsp(1'b0, 32'h0000_0013);
    drive(1'b1, 1'b0, 32'h0); step();
    chk("ifu_wait_busy", {127'd0, busy_o}, 128'd1);
    drive(1'b0, 1'b1, 32'h0000_0013); step();
    chk("ifu_idle_after", {126'd0, busy_o, mem_req_o}, 128'd0);

    // Simultaneous requests: LSU write goes first, IFU on the next transaction.
    ifu_req_i = 1'b1; ifu_addr_i = 32'h8000_0004;
    lsu_req_i = 1'b1; lsu_we_i = 1'b1; lsu_be_i = 4'b0011;
    lsu_addr_i = 32'h0000_1000; lsu_wdata_i = 32'hDEAD_BEEF;
    push_gnt(1'b1, 1'b1, 4'b0011, 32'h0000_1000, 32'hDEAD_BEEF);
    push_rsp(1'b1, 32'h0);
    push_gnt(1'b0, 1'b0, 4'b1111, 32'h8000_0004, 32'h0);
    push_rsp(1'b0, 32'h0000_0093);
    drive(1'b1, 1'b0, 32'h0); step();
    drive(1'b0, 1'b1, 32'h0); step();
    drive(1'b1, 1'b0, 32'h0); step();
    drive(1'b0, 1'b1, 32'h0000_0093); step();

    // Both sides requesting continuously: L,L,L,L,I repeating.
    lsu_we_i = 1'b0; lsu_be_i = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      ifu_req_i = 1'b1; ifu_addr_i = 32'h0000_0100 + 32'(i * 4);
      lsu_req_i = 1'b1; lsu_addr_i = 32'h0000_2000 + 32'(i * 4); lsu_wdata_i = 32'(i);
      if ((i % 5) == 4) push_gnt(1'b0, 1'b0, 4'b1111, ifu_addr_i, 32'h0);
      else              push_gnt(1'b1, 1'b0, 4'b1111, lsu_addr_i, lsu_wdata_i);
      push_rsp((i % 5) != 4, 32'hA000_0000 + 32'(i));
      drive(1'b1, 1'b0, 32'h0); step();
      drive(1'b0, 1'b1, 32'hA000_0000 + 32'(i)); step();
    end
    lsu_req_i = 1'b0;

    // Stalled grant: IFU owner stays locked while the LSU request arrives mid-stall.
    ifu_req_i = 1'b1; ifu_addr_i = 32'h8000_0040;
    push_gnt(1'b0, 1'b0, 4'b1111, 32'h8000_0040, 32'h0);
    push_rsp(1'b0, 32'h0000_0011);
    push_gnt(1'b1, 1'b1, 4'b1111, 32'h0000_3000, 32'h1234_5678);
    push_rsp(1'b1, 32'h0);
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin
        lsu_req_i = 1'b1; lsu_we_i = 1'b1; lsu_be_i = 4'b1111;
        lsu_addr_i = 32'h0000_3000; lsu_wdata_i = 32'h1234_5678;
      end
      drive(1'b0, 1'b0, 32'h0);
      chk($sformatf("stall_c%0d", c), {mem_req_o, mem_we_o, mem_be_o, mem_addr_o},
          {1'b1, 1'b0, 4'b1111, 32'h8000_0040});
      step();
    end
    drive(1'b1, 1'b0, 32'h0); step();
    drive(1'b0, 1'b1, 32'h0000_0011); step();
    drive(1'b1, 1'b0, 32'h0); step();
    drive(1'b0, 1'b1, 32'h0); step();

    // Spurious rvalid and gnt in IDLE.
    drive(1'b1, 1'b1, 32'h0000_ABCD);
    chk("idle_spurious", {ifu_rvalid_o, lsu_rvalid_o, ifu_gnt_o, lsu_gnt_o, mem_req_o}, 128'd0);
    step();
    chk("idle_stays", {127'd0, busy_o}, 128'd0);

    // Spurious rvalid while waiting for a grant.
    ifu_req_i = 1'b1; ifu_addr_i = 32'h0000_0044;
    push_gnt(1'b0, 1'b0, 4'b1111, 32'h0000_0044, 32'h0);
    push_rsp(1'b0, 32'h0000_0055);
    drive(1'b0, 1'b0, 32'h0); step();
    drive(1'b0, 1'b1, 32'h0000_BEEF);
    chk("req_spurious", {126'd0, ifu_rvalid_o, lsu_rvalid_o}, 128'd0);
    step();
    chk("req_stays", {126'd0, busy_o, mem_req_o}, 128'd3);
    drive(1'b1, 1'b0, 32'h0); step();
    drive(1'b0, 1'b1, 32'h0000_0055); step();

    // Reset in WAIT: outputs drop asynchronously, the response is dropped.
    ifu_req_i = 1'b1; ifu_addr_i = 32'h0000_0060;
    push_gnt(1'b0, 1'b0, 4'b1111, 32'h0000_0060, 32'h0);
    drive(1'b1, 1'b0, 32'h0); step();
    chk("pre_reset_busy", {127'd0, busy_o}, 128'd1);
    lsu_req_i = 1'b1; lsu_addr_i = 32'h0000_7000; lsu_we_i = 1'b1;
    mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1;
    #1;
    rstn_i = 1'b0;
    #1;
    chk("reset_async", {busy_o, mem_req_o, ifu_gnt_o, lsu_gnt_o, ifu_rvalid_o, lsu_rvalid_o,
                        mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o}, 128'd0);
    @(posedge clk_i);
    #1;
    lsu_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
    rstn_i = 1'b1;
    #2;
    chk("post_reset_idle", {125'd0, busy_o, mem_req_o, ifu_rvalid_o}, 128'd0);
    step();
    chk("post_reset_stays", {126'd0, busy_o, mem_req_o}, 128'd0);

    chk("gnt_queue_empty", 128'(exp_gnt.size()), 128'd0);
    chk("rsp_queue_empty", 128'(exp_rsp.size()), 128'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
